bcd_display_mux: RTL
====================

// Module: bcd_display_mux
// PURPOSE
//  Time-multiplexed seven-segment driver; sits directly downstream of the binary-to-BCD converter.
//  Captures a packed BCD word on a load strobe and double-buffers it, applying it only at frame boundaries (no tearing).
//  Scans one digit at a time and emits active-low anode/segment drives for a common-anode display.
// PARAMETERS
//  DIGITS        10      number of BCD nibbles/digits (10 matches the 31-bit converter output)
//  SCAN_DIV      100000  clk cycles per digit slot; >= BLANK_CYCLES+2
//  BLANK_CYCLES  16      cycles at start of each slot with all anodes off (anti-ghosting); >= 1
// PORTS
//  clk         in   1           system clock, rising edge
//  rst_n       in   1           asynchronous active-low reset
//  bcd_in      in   4*DIGITS    packed BCD, nibble 0 (bits [3:0]) = least significant digit
//  load        in   1           1-cycle capture strobe for bcd_in
//  an_n        out  DIGITS      anode enables, active low, at most one low at a time
//  seg_n       out  7           {g,f,e,d,c,b,a}, active low
//  frame_done  out  1           1-cycle pulse on the cycle the digit index wraps DIGITS-1 -> 0
// BEHAVIOUR
//  Reset: one clock; reset is asynchronous and active-low. While rst_n=0: an_n all 1, seg_n=7'h7F,
//   frame_done=0, prescaler=0, digit index=0, shadow/active regs=0, pending=0. Takes effect immediately, mid-slot included.
//  Prescaler counts 0..SCAN_DIV-1 and wraps; on wrap digit index increments, DIGITS-1 wraps to 0.
//  Per-slot FSM: BLANK (prescaler < BLANK_CYCLES) -> DRIVE (rest of slot) -> BLANK on prescaler wrap.
//   BLANK: an_n all 1, seg_n=7'h7F. DRIVE: an_n[idx]=0 (others 1), seg_n=decode(active nibble idx).
//  All outputs registered; an_n/seg_n change on the same edge as prescaler state (no combinational outputs).
//  Decode (seg_n): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex); nibble A-F -> 7'h3F ('-').
//  load=1: bcd_in -> shadow, pending=1. Repeated loads before boundary: latest wins.
//  Frame boundary (cycle idx wraps to 0): frame_done=1; if pending, shadow -> active, pending=0.
//  Simultaneous load and boundary: bcd_in written directly to active, pending cleared; shown in the new frame.
//  Active register never changes except at a boundary; a frame always displays one coherent value.
//  Frame period = DIGITS*SCAN_DIV cycles; first frame_done occurs DIGITS*SCAN_DIV cycles after reset release.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: digit k (k>0) is suppressed when nibbles k..DIGITS-1 of active are all 4'h0;
//   suppressed slot keeps an_n all 1 and seg_n=7'h7F for the whole slot. Digit 0 is never suppressed.
//   Nibbles A-F count as non-zero. Suppression evaluated from active register, so it changes only at boundaries.
//  Not defined: all DIGITS slots drive normally, leading zeros display as 7'h40.
// TESTING  (DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2)
//  Assert rst_n=0 mid-DRIVE -> an_n=4'hF, seg_n=7'h7F same cycle without clk edge; after release first an_n=4'hE at cycle 2.
//  load 16'h1234, wait boundary -> slots 0..3 show seg_n 19,30,24,79 with an_n E,D,B,7; frame_done every 32 cycles.
//  load 16'h5678 mid-frame -> current frame still shows 1234; next frame shows 5678; 2 loads in one frame -> last wins.
//  load coincident with frame_done -> value visible in the frame starting that cycle.
//  load 16'h00A9 -> slot 1 seg_n=7'h3F, slot 0 seg_n=7'h10; an_n never has two bits low in any cycle.
//  load 16'h0050 -> with LEADING_ZERO_BLANK_EN slots 3,2 an_n=4'hF, slot1 7'h12, slot0 7'h40; without: slots 3,2 show 7'h40;
//   load 16'h0000 with macro -> only digit 0 lit, seg_n=7'h40.

Source files
------------

// File: rtl/bcd_display_mux.sv
// rtl/bcd_display_mux.sv - time-multiplexed common-anode seven-segment driver for packed BCD
// Optional LEADING_ZERO_BLANK_EN: blank leading zero digits of the active value (digit 0 always lit).
module bcd_display_mux #(
  parameter int DIGITS       = 10,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  load,
  output logic [DIGITS-1:0]     an_n,
  output logic [6:0]            seg_n,
  output logic                  frame_done
);

  localparam int PSC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PSC_W-1:0] PSC_MAX   = PSC_W'(SCAN_DIV - 1);
  localparam logic [PSC_W-1:0] PSC_BLANK = PSC_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(DIGITS - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  logic [PSC_W-1:0]          psc_q, psc_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [0:0]                state_q, state_d;
  logic [DIGITS-1:0][3:0]    shadow_q, shadow_d;
  logic [DIGITS-1:0][3:0]    active_q, active_d;
  logic                      pending_q, pending_d;
  logic [DIGITS-1:0]         an_n_q, an_n_d;
  logic [6:0]                seg_n_q, seg_n_d;
  logic                      frame_done_q, frame_done_d;

  logic                      psc_wrap;
  logic                      lit;
  logic [3:0]                digit;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  always_comb begin
    psc_wrap     = (psc_q == PSC_MAX);
    psc_d        = psc_wrap ? '0 : psc_q + 1'b1;
    idx_d        = idx_q;
    if (psc_wrap) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
    frame_done_d = psc_wrap && (idx_q == IDX_MAX);
  end

  // The swap happens at the end of the frame_done cycle; slot 0 is still blanking
  // then, so a load landing in that cycle is shown for the whole new frame.
  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    active_d  = active_q;
    if (load) begin
      shadow_d  = bcd_in;
      pending_d = 1'b1;
    end
    if (frame_done_q) begin
      if (load) begin
        active_d = bcd_in;
      end else if (pending_q) begin
        active_d = shadow_q;
      end
      pending_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: state_d = (psc_d >= PSC_BLANK) ? ST_DRIVE : ST_BLANK;
      default:  state_d = psc_wrap ? ST_BLANK : ST_DRIVE;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lead_zero;
  logic              upper_zero;

  always_comb begin
    lead_zero  = '0;
    upper_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      upper_zero   = upper_zero && (active_d[k] == 4'h0);
      lead_zero[k] = upper_zero;
    end
  end

  assign lit = (state_d == ST_DRIVE) && !lead_zero[idx_d];
`else
  assign lit = (state_d == ST_DRIVE);
`endif

  // Drives are computed from next-state values so they move on the same edge as the prescaler.
  always_comb begin
    digit   = active_d[idx_d];
    an_n_d  = '1;
    seg_n_d = 7'h7F;
    if (lit) begin
      an_n_d[idx_d] = 1'b0;
      seg_n_d       = seg_decode(digit);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q        <= '0;
      idx_q        <= '0;
      state_q      <= ST_BLANK;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      an_n_q       <= '1;
      seg_n_q      <= 7'h7F;
      frame_done_q <= 1'b0;
    end else begin
      psc_q        <= psc_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      an_n_q       <= an_n_d;
      seg_n_q      <= seg_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign frame_done = frame_done_q;

endmodule
